fun_fpsu_ret_collect: RTL
=========================

// Module: fun_fpsu_ret_collect
// PURPOSE
//  Receiver/drain end of the FP add/sub unit's retire interface. Captures up to three
//  completion words per cycle (u1/u3/u5 ret + ret_en) into one shared FIFO.
//  Drains one word per cycle to the retire/ROB side with a valid/ready handshake.
//  Raises fu_stall so the issue stage stops feeding the FP unit before the FIFO overflows.
// PARAMETERS
//  DEPTH      8   FIFO entries; power of two, >=4
//  AW         3   log2(DEPTH); pointer width
//  STALL_THR  6   fu_stall asserted while free entries < STALL_THR (covers 3-deep FP pipe x 3 ports / 1.5)
// PORTS
//  clk        in   1      clock; all state on posedge (negedge when swapedge is defined)
//  rst        in   1      asynchronous, active-low reset
//  u1_ret     in   14     completion word, port u1 (opaque payload)
//  u1_ret_en  in   1      u1_ret valid this cycle
//  u3_ret     in   14     completion word, port u3
//  u3_ret_en  in   1      u3_ret valid
//  u5_ret     in   14     completion word, port u5
//  u5_ret_en  in   1      u5_ret valid
//  flush      in   1      discard all queued and same-cycle words
//  out_data   out  14     head-of-FIFO payload
//  out_port   out  2      source of head: 0=u1, 1=u3, 2=u5 (3 never driven)
//  out_valid  out  1      FIFO non-empty
//  out_ready  in   1      consumer accepts head when out_valid&out_ready
//  fu_stall   out  1      (DEPTH-count) < STALL_THR; decoded from registered count
//  count      out  AW+1   current occupancy, 0..DEPTH
//  ovf        out  1      sticky: a ret_en word was dropped for lack of space
//  ovf_clr    in   1      clears ovf (set in the same cycle wins)
// BEHAVIOUR
//  - Reset (rst=0, async): rd/wr pointers=0, count=0, ovf=0; hence out_valid=0,
//    fu_stall=(DEPTH<STALL_THR), out_data/out_port=0. Storage array not reset.
//  - Entry = {port[1:0], ret[13:0]}; 16 bits.
//  - Write: enabled inputs are packed in fixed order u1, u3, u5 into consecutive slots
//    starting at wr_ptr. Pointer wraps modulo DEPTH.
//  - Space check uses free = DEPTH - count (pre-read value). A pop in the same cycle
//    does NOT free space for that cycle's writes.
//  - Partial accept: if #enabled > free, the first 'free' words in u1,u3,u5 order are
//    written; the rest are dropped and ovf sets next cycle.
//  - Read: out_data/out_port are a combinational view of mem[rd_ptr]; valid only when
//    out_valid=1. Pop occurs on out_valid&out_ready; rd_ptr+1.
//  - count_next = count + n_accepted - pop. Range 0..DEPTH; wrap-free by construction.
//  - Latency: a word written in cycle N is visible at out_* in cycle N+1 (no bypass
//    when empty).
//  - flush=1: next cycle pointers=0 and count=0. Same-cycle writes and pops are
//    discarded. ovf is held, except that ovf_clr still acts.
//  - ovf: set by any drop; cleared by ovf_clr when no drop occurs in that cycle.
//  - fu_stall is advisory. The block never back-pressures ret_en; producers that
//    ignore fu_stall risk drops, which are flagged via ovf.
//  - Reset asserted mid-operation: all contents are lost immediately; out_valid drops
//    asynchronously.
// TESTING
//  1. Reset, then u1/u3/u5 ret_en=1 with 0x0011/0x0022/0x0033, out_ready=1
//     -> pops 0x0011/p0, 0x0022/p1, 0x0033/p2 in cycles N+1..N+3; count peaks 3.
//  2. out_ready=0, 3 words/cycle for 3 cycles (DEPTH=8) -> cycle 3 accepts u1,u3 only,
//     u5 dropped; count=8; ovf=1; fu_stall=1 from count>=3.
//  3. count=7, out_ready=1, u1+u3 enabled -> u1 accepted, u3 dropped (no same-cycle
//     credit); count stays 7; ovf=1.
//  4. Queue 5 words, pulse flush together with u5_ret_en=1 -> next cycle count=0,
//     out_valid=0, u5 word absent, ovf unchanged.
//  5. Pointer wrap: 20 single-port writes with continuous pop, payloads 0..19 -> output
//     sequence is exactly 0..19 with no gaps; ovf=0.
//  6. Drop and ovf_clr in the same cycle -> ovf=1; ovf_clr alone next cycle -> ovf=0.

Source files
------------

// File: rtl/fun_fpsu_ret_collect.sv
// fun_fpsu_ret_collect
// Drain end of the FP add/sub retire interface. Up to three completion words per
// cycle (ports u1, u3, u5) are packed into one shared FIFO and drained one word per
// cycle towards the retire/ROB side. fu_stall warns the issue stage early enough
// that a full FP pipeline can still land; anything that does not fit is dropped and
// recorded in the sticky ovf flag.
//
// Output handshake: out_valid is high whenever the FIFO holds at least one word and
// does not depend on out_ready; out_data/out_port are stable while out_valid is high
// and no transfer occurs; a word transfers on a rising edge where
// out_valid && out_ready, and the next word (if any) is presented the cycle after.

module fun_fpsu_ret_collect #(
   parameter int DEPTH     = 8,
   parameter int AW        = 3,
   parameter int STALL_THR = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [13:0]   u1_ret,
   input  logic          u1_ret_en,
   input  logic [13:0]   u3_ret,
   input  logic          u3_ret_en,
   input  logic [13:0]   u5_ret,
   input  logic          u5_ret_en,
   input  logic          flush,
   output logic [13:0]   out_data,
   output logic [1:0]    out_port,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          fu_stall,
   output logic [AW:0]   count,
   output logic          ovf,
   input  logic          ovf_clr
);

   localparam logic [AW:0]   DEPTH_W     = DEPTH[AW:0];
   localparam logic [AW+1:0] STALL_THR_W = STALL_THR[AW+1:0];

   // Active clock edge; builds that define swapedge run all state on the falling edge.
   logic clk_e;
`ifdef swapedge
   assign clk_e = ~clk;
`else
   assign clk_e = clk;
`endif

   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;

   logic [AW:0]   free;
   logic [1:0]    slot3;
   logic [1:0]    slot5;
   logic          acc1;
   logic          acc3;
   logic          acc5;
   logic          drop;
   logic [1:0]    n_acc;
   logic          pop;
   logic [AW:0]   count_next;

   // Slot assignment and space check. Space is judged on the occupancy at the start
   // of the cycle, so a same-cycle pop never makes room for same-cycle writes. Words
   // take consecutive slots in u1, u3, u5 order, so the accepted set is always a
   // prefix of the enabled set and partial accepts keep that order.
   always_comb begin
      free       = DEPTH_W - count;
      slot3      = {1'b0, u1_ret_en};
      slot5      = {1'b0, u1_ret_en} + {1'b0, u3_ret_en};
      acc1       = u1_ret_en && (free != '0);
      acc3       = u3_ret_en && ((AW+1)'(slot3) < free);
      acc5       = u5_ret_en && ((AW+1)'(slot5) < free);
      drop       = (u1_ret_en && !acc1) || (u3_ret_en && !acc3) || (u5_ret_en && !acc5);
      n_acc      = {1'b0, acc1} + {1'b0, acc3} + {1'b0, acc5};
      pop        = out_valid && out_ready;
      count_next = count + (AW+1)'(n_acc) - (AW+1)'(pop);
   end

   // Storage: not reset; only accepted words are written, and nothing during flush.
   always_ff @(posedge clk_e) begin
      if (!flush) begin
         if (acc1) mem[wr_ptr]                  <= {2'd0, u1_ret};
         if (acc3) mem[wr_ptr + AW'(slot3)]     <= {2'd1, u3_ret};
         if (acc5) mem[wr_ptr + AW'(slot5)]     <= {2'd2, u5_ret};
      end
   end

   // Pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk_e or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else if (flush) begin
         // Same-cycle writes, pops and drops are all discarded; only ovf_clr acts.
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         if (ovf_clr) ovf <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + AW'(n_acc);
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count  <= count_next;
         // A drop in the same cycle outranks a clear.
         if (drop)         ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
      end
   end

   // Head view and status decode, all derived from registered state.
   always_comb begin
      out_valid = (count != '0);
      out_data  = out_valid ? mem[rd_ptr][13:0]  : 14'd0;
      out_port  = out_valid ? mem[rd_ptr][15:14] : 2'd0;
      fu_stall  = ({1'b0, free} < STALL_THR_W);
   end

endmodule
